// File: rtl/uart_rcv_cfg.sv
// uart_rcv_cfg - configurable UART receiver (start, DATA_BITS data LSB first,
// optional even/odd parity, 1 or 2 stop bits).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   RX         asynchronous serial input, idle high
//   clr_rx_rdy consumer pulse: clears rx_rdy, frame_err, parity_err, overrun
//   rx_rdy     a completed frame is held in rx_data
//   rx_data    last received word, LSB = first bit on the wire
//   frame_err  a stop bit of the held frame sampled low
//   parity_err parity mismatch on the held frame (0 when PARITY = 0)
//   overrun    a frame completed while rx_rdy was still high
//
// Build option: define UART_RCV_MAJORITY_EN to take every bit sample as the
// 2-of-3 majority of the last three synchronised RX values.
module uart_rcv_cfg #(
  parameter int CLK_PER_BAUD = 2604,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 clr_rx_rdy,
  output logic                 rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW   = $clog2(CLK_PER_BAUD);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int HALF = CLK_PER_BAUD / 2;
  localparam logic [CW-1:0] HALF_TERM = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_TERM = CW'(CLK_PER_BAUD - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_reg, state_next;
  logic                 rx_meta_reg, rxs_reg, rxs_d1_reg;
  logic [CW-1:0]        baud_cnt_reg, baud_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [1:0]           stop_cnt_reg, stop_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 stop_ok_reg, stop_ok_next;
  logic                 rx_rdy_reg, rx_rdy_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 overrun_reg, overrun_next;
  logic                 sample_bit, baud_tick, fall, done, par_calc;

  // Two-flop synchroniser plus one extra delayed copy used for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
      rxs_d1_reg  <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rxs_reg     <= rx_meta_reg;
      rxs_d1_reg  <= rxs_reg;
    end
  end

`ifdef UART_RCV_MAJORITY_EN
  logic rxs_d2_reg;
  always_ff @(posedge clk) begin
    if (rst) rxs_d2_reg <= 1'b1;
    else     rxs_d2_reg <= rxs_d1_reg;
  end
  // A single-clock spike on the line cannot outvote its two neighbours.
  assign sample_bit = (rxs_reg & rxs_d1_reg) | (rxs_reg & rxs_d2_reg) |
                      (rxs_d1_reg & rxs_d2_reg);
`else
  assign sample_bit = rxs_reg;
`endif

  assign fall      = rxs_d1_reg & ~rxs_reg;
  // START waits only half a bit so every later sample lands mid-bit.
  assign baud_tick = (state_reg == S_START) ? (baud_cnt_reg == HALF_TERM)
                                            : (baud_cnt_reg == FULL_TERM);
  assign par_calc  = ^{shift_reg, par_bit_reg};

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_tick ? '0 : baud_cnt_reg + CW'(1);
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    shift_next    = shift_reg;
    par_bit_next  = par_bit_reg;
    stop_ok_next  = stop_ok_reg;
    done          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        baud_cnt_next = '0;
        if (fall) begin
          bit_cnt_next  = '0;
          stop_cnt_next = '0;
          stop_ok_next  = 1'b1;
          state_next    = S_START;
        end
      end
      S_START: begin
        if (baud_tick) state_next = sample_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_next   = {sample_bit, shift_reg[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + BW'(1);
          if (bit_cnt_reg == BW'(DATA_BITS - 1))
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          par_bit_next = sample_bit;
          state_next   = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          stop_ok_next  = stop_ok_reg & sample_bit;
          stop_cnt_next = stop_cnt_reg + 2'd1;
          // Finish at mid-stop so a directly following start edge is seen.
          if (stop_cnt_reg == 2'(STOP_BITS - 1)) begin
            done       = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Consumer-visible result registers; a completing frame beats a clear.
  always_comb begin
    rx_rdy_next     = rx_rdy_reg;
    rx_data_next    = rx_data_reg;
    frame_err_next  = frame_err_reg;
    parity_err_next = parity_err_reg;
    overrun_next    = overrun_reg;
    if (done) begin
      rx_rdy_next     = 1'b1;
      rx_data_next    = shift_reg;
      frame_err_next  = ~stop_ok_next;
      parity_err_next = (PARITY != 0) && (par_calc != (PARITY == 2));
      if (clr_rx_rdy)      overrun_next = 1'b0;
      else if (rx_rdy_reg) overrun_next = 1'b1;
    end else if (clr_rx_rdy) begin
      rx_rdy_next     = 1'b0;
      frame_err_next  = 1'b0;
      parity_err_next = 1'b0;
      overrun_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      stop_cnt_reg   <= '0;
      shift_reg      <= '0;
      par_bit_reg    <= 1'b0;
      stop_ok_reg    <= 1'b0;
      rx_rdy_reg     <= 1'b0;
      rx_data_reg    <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      baud_cnt_reg   <= baud_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      stop_cnt_reg   <= stop_cnt_next;
      shift_reg      <= shift_next;
      par_bit_reg    <= par_bit_next;
      stop_ok_reg    <= stop_ok_next;
      rx_rdy_reg     <= rx_rdy_next;
      rx_data_reg    <= rx_data_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign rx_rdy     = rx_rdy_reg;
  assign rx_data    = rx_data_reg;
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rcv_cfg.sv
// Bench for uart_rcv_cfg: dut0 is 8N1, dut1 is 8E1, both at 16 clk per bit.
// Stimulus pushes the expected frame into a per-DUT queue; a negedge monitor
// pops and compares whenever a DUT presents a new frame.
module tb_uart_rcv_cfg;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
    int         start;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line  [2];
  logic       clr_line [2];
  logic       rdy      [2];
  logic [7:0] data     [2];
  logic       fe       [2];
  logic       pe       [2];
  logic       ov       [2];
  logic       prev_rdy [2];
  logic [7:0] prev_data[2];
  logic       prev_ov  [2];
  exp_t       q0[$];
  exp_t       q1[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] maj_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rcv_cfg #(.CLK_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .RX(rx_line[0]), .clr_rx_rdy(clr_line[0]),
    .rx_rdy(rdy[0]), .rx_data(data[0]), .frame_err(fe[0]),
    .parity_err(pe[0]), .overrun(ov[0]));

  uart_rcv_cfg #(.CLK_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .RX(rx_line[1]), .clr_rx_rdy(clr_line[1]),
    .rx_rdy(rdy[1]), .rx_data(data[1]), .frame_err(fe[1]),
    .parity_err(pe[1]), .overrun(ov[1]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Monitor: a frame is presented when rx_rdy rises, or while rx_rdy stays
  // high the data changes or overrun rises.
  task automatic mon(input int d);
    exp_t e;
    int   lat_got;
    logic trig;
    trig = rdy[d] && (!prev_rdy[d] || data[d] != prev_data[d] || (ov[d] && !prev_ov[d]));
    if (trig) begin
      if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame dut%0d got data %02h want no frame", d, data[d]);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        lat_got = cyc - e.start;
        $display("frame dut%0d data %02h fe %0b pe %0b ov %0b latency %0d",
                 d, data[d], fe[d], pe[d], ov[d], lat_got);
        chk($sformatf("dut%0d_data", d), 32'(data[d]), 32'(e.data));
        chk($sformatf("dut%0d_frame_err", d), 32'(fe[d]), 32'(e.fe));
        chk($sformatf("dut%0d_parity_err", d), 32'(pe[d]), 32'(e.pe));
        chk($sformatf("dut%0d_overrun", d), 32'(ov[d]), 32'(e.ov));
        checks++;
        if (lat_got < e.lat - 1 || lat_got > e.lat + 1) begin
          errors++;
          $display("FAIL dut%0d_latency got %0d want %0d +-1", d, lat_got, e.lat);
        end
      end
    end
    prev_rdy[d]  = rdy[d];
    prev_data[d] = data[d];
    prev_ov[d]   = ov[d];
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  // Drive one frame on dut d, one bit per CPB negedges. spikes inverts RX for
  // one clock at each data bit's mid-sample point; clr_done raises clr_rx_rdy
  // on exactly the cycle the frame completes.
  task automatic send(input int d, input logic [7:0] val, input logic pbit,
                      input logic stopv, input logic spikes, input logic clr_done,
                      input logic [7:0] e_data, input logic e_fe, input logic e_pe,
                      input logic e_ov);
    exp_t e;
    int   nbits, bi, l;
    logic v;
    nbits = (d == 1) ? 11 : 10;
    l     = 3 + HALF + (nbits - 1) * CPB;
    for (int t = 0; t < nbits * CPB; t++) begin
      @(negedge clk);
      if (t == 0) begin
        e.data = e_data; e.fe = e_fe; e.pe = e_pe; e.ov = e_ov;
        e.start = cyc; e.lat = l;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      bi = t / CPB;
      if (bi == 0)                  v = 1'b0;
      else if (bi <= 8)             v = val[bi-1] ^ (spikes && (t == HALF + bi * CPB));
      else if (bi == 9 && d == 1)   v = pbit;
      else                          v = stopv;
      rx_line[d] = v;
      if (clr_done) clr_line[d] = (t == l - 1);
    end
    clr_line[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_and_check(input int d);
    @(negedge clk); clr_line[d] = 1'b1;
    @(negedge clk); clr_line[d] = 1'b0;
    chk($sformatf("dut%0d_clr_rdy", d), 32'(rdy[d]), 32'd0);
    chk($sformatf("dut%0d_clr_flags", d), {29'd0, fe[d], pe[d], ov[d]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rx_line[d] = 1'b1; clr_line[d] = 1'b0;
      prev_rdy[d] = 1'b0; prev_data[d] = 8'h00; prev_ov[d] = 1'b0;
    end
    idle(4);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_reset_rdy", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("dut%0d_reset_data", d), 32'(data[d]), 32'd0);
      chk($sformatf("dut%0d_reset_flags", d), {29'd0, fe[d], pe[d], ov[d]}, 32'd0);
    end
    rst = 1'b0;
    idle(3 * CPB);

    // Plain 8N1 frame.
    send(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    rx_line[0] = 1'b1;
    idle(2 * CPB);

    // Three-clock low glitch on the idle line is a false start.
    rx_line[0] = 1'b0; idle(3); rx_line[0] = 1'b1;
    idle(3 * CPB);
    chk("glitch_rdy", 32'(rdy[0]), 32'd1);
    chk("glitch_data", 32'(data[0]), 32'hA5);
    chk("glitch_flags", {29'd0, fe[0], pe[0], ov[0]}, 32'd0);
    clear_and_check(0);

    // Stop bit low, then a held-low break for 40 bit times.
    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    idle(40 * CPB);
    rx_line[0] = 1'b1;
    idle(2 * CPB);
    clear_and_check(0);
    send(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    rx_line[0] = 1'b1;
    idle(2 * CPB);
    clear_and_check(0);

    // Back-to-back frames without a clear: overrun.
    send(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    rx_line[0] = 1'b1;
    idle(2 * CPB);
    clear_and_check(0);

    // Clear coincident with completion: new frame wins, no overrun.
    send(0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    send(0, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    rx_line[0] = 1'b1;
    idle(2 * CPB);
    chk("coincident_rdy", 32'(rdy[0]), 32'd1);
    clear_and_check(0);

    // One-clock spikes at every data sample point.
`ifdef UART_RCV_MAJORITY_EN
    maj_exp = 8'hC3;
`else
    maj_exp = 8'h3C;
`endif
    send(0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, maj_exp, 1'b0, 1'b0, 1'b0);
    rx_line[0] = 1'b1;
    idle(2 * CPB);
    clear_and_check(0);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1.
    send(1, 8'h37, 1'b1, 1'b1, 1'b0, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0);
    rx_line[1] = 1'b1;
    idle(2 * CPB);
    clear_and_check(1);
    send(1, 8'h37, 1'b0, 1'b1, 1'b0, 1'b0, 8'h37, 1'b0, 1'b1, 1'b0);
    rx_line[1] = 1'b1;
    idle(2 * CPB);
    chk("bad_parity_rdy", 32'(rdy[1]), 32'd1);

    idle(4 * CPB);
    chk("dut0_pending_frames", 32'(q0.size()), 32'd0);
    chk("dut1_pending_frames", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
